// File: rtl/gin_id_cfg_ctrl.sv
// ID-table sequencer for one GIN bus scan chain: host-written table, shifted into the chain on start.
// Optional readback pass enabled by defining GIN_CFG_VERIFY_EN.
module gin_id_cfg_ctrl #(
    parameter int NUMS_SLAVE = 4,
    parameter int ID_SIZE    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(NUMS_SLAVE)-1:0] cfg_addr,
    input  logic [ID_SIZE-1:0]            cfg_wdata,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          verify_err,
    output logic                          bus_hold,
    output logic                          set_id,
    output logic [ID_SIZE-1:0]            ID_scan_in,
    input  logic [ID_SIZE-1:0]            ID_scan_out
);

    localparam int CW = $clog2(NUMS_SLAVE);
    localparam logic [CW-1:0] CNT_MAX = CW'(NUMS_SLAVE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_VERIFY = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ID_SIZE-1:0]  id_tab [NUMS_SLAVE];
    logic                addr_ok;
    logic                wr_ok;
    logic                shifting_d;
    logic [ID_SIZE-1:0]  scan_d;

    generate
        if ((2 ** CW) == NUMS_SLAVE) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = ({1'b0, cfg_addr} < (CW + 1)'(NUMS_SLAVE));
        end
    endgenerate

    assign wr_ok = cfg_we && addr_ok && (state_q == S_IDLE);

    // Table has no reset: the host's contents survive rst so a re-start reloads them.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            id_tab[cfg_addr] <= cfg_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_MAX;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
`ifdef GIN_CFG_VERIFY_EN
                    state_d = S_VERIFY;
                    cnt_d   = CNT_MAX;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_VERIFY: begin
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign shifting_d = (state_d == S_SHIFT) || (state_d == S_VERIFY);

    // A write landing on the start edge must be seen by the first shift, so forward it.
    always_comb begin
        scan_d = id_tab[cnt_d];
        if (wr_ok && (cfg_addr == cnt_d)) begin
            scan_d = cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            set_id     <= 1'b0;
            ID_scan_in <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            set_id     <= shifting_d;
            ID_scan_in <= shifting_d ? scan_d : '0;
            busy       <= shifting_d;
            done       <= (state_d == S_FIN);
        end
    end

    assign bus_hold = busy;

`ifdef GIN_CFG_VERIFY_EN
    // In VERIFY the last stage presents table[cnt] while that same value is re-shifted in.
    always_ff @(posedge clk) begin
        if (rst) begin
            verify_err <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            verify_err <= 1'b0;
        end else if ((state_q == S_VERIFY) && (ID_scan_out != id_tab[cnt_q])) begin
            verify_err <= 1'b1;
        end
    end
`else
    logic unused_scan_out;
    assign unused_scan_out = ^ID_scan_out;
    assign verify_err      = 1'b0;
`endif

endmodule

// File: tb/tb_gin_id_cfg_ctrl.sv
// Bench for gin_id_cfg_ctrl: directed vector table, corner sequences and random traffic
// checked against a queue-based expected-trace model driving a behavioural scan chain.
module tb_gin_id_cfg_ctrl;

    localparam int N  = 4;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [IW-1:0] cfg_wdata;
    logic          start;
    logic          busy;
    logic          done;
    logic          verify_err;
    logic          bus_hold;
    logic          set_id;
    logic [IW-1:0] ID_scan_in;
    logic [IW-1:0] ID_scan_out;

    gin_id_cfg_ctrl #(.NUMS_SLAVE(N), .ID_SIZE(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .verify_err (verify_err),
        .bus_hold   (bus_hold),
        .set_id     (set_id),
        .ID_scan_in (ID_scan_in),
        .ID_scan_out(ID_scan_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural chain: stage 0 takes ID_scan_in, last stage drives ID_scan_out.
    logic [IW-1:0] chain [N];
    logic          stuck2;
    always @(posedge clk) begin
        if (set_id) begin
            chain[0] <= ID_scan_in;
            chain[1] <= chain[0];
            chain[2] <= stuck2 ? '0 : chain[1];
            chain[3] <= chain[2];
        end
    end
    assign ID_scan_out = chain[N-1];

    typedef struct packed {
        logic          sid;
        logic [IW-1:0] d;
        logic          dn;
        logic          vfy;
    } ent_t;

    typedef struct {
        logic          r;
        logic          we;
        logic [1:0]    a;
        logic [IW-1:0] wd;
        logic          st;
        logic          sid;
        logic [IW-1:0] d;
        logic          bsy;
        logic          dn;
    } vec_t;

    ent_t          q[$];
    ent_t          cur;
    logic [IW-1:0] m_tab [N];
    logic          m_verr;
    int            n_tests;
    int            n_fail;
    int            done_cnt;
    int            sid_cnt;
    bit            verify_on;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected trace of one accepted start: N shifts (last column first), optional verify pass, done.
    task automatic build_trace();
        ent_t e;
        for (int k = N - 1; k >= 0; k--) begin
            e = '{sid: 1'b1, d: m_tab[k], dn: 1'b0, vfy: 1'b0};
            q.push_back(e);
        end
        if (verify_on) begin
            for (int k = N - 1; k >= 0; k--) begin
                e = '{sid: 1'b1, d: m_tab[k], dn: 1'b0, vfy: 1'b1};
                q.push_back(e);
            end
        end
        e = '{sid: 1'b0, d: '0, dn: 1'b1, vfy: 1'b0};
        q.push_back(e);
    endtask

    task automatic tick(input logic r, input logic we, input logic [1:0] a,
                        input logic [IW-1:0] wd, input logic st);
        logic [IW-1:0] chain_before;
        logic          was_idle;
        rst = r; cfg_we = we; cfg_addr = a; cfg_wdata = wd; start = st;
        chain_before = ID_scan_out;
        was_idle = !(cur.sid || cur.dn);
        @(posedge clk);
        if (r) begin
            q.delete();
            cur    = '0;
            m_verr = 1'b0;
        end else begin
            if (cur.vfy && (chain_before != cur.d)) m_verr = 1'b1;
            if (was_idle) begin
                if (we) m_tab[a] = wd;
                if (st) begin
                    m_verr = 1'b0;
                    build_trace();
                end
            end
            cur = (q.size() > 0) ? q.pop_front() : ent_t'('0);
        end
        #1;
        if (done === 1'b1) done_cnt++;
        if (set_id === 1'b1) sid_cnt++;
        chk("cycle", {busy, bus_hold, done, set_id, ID_scan_in, verify_err},
                     {cur.sid, cur.sid, cur.dn, cur.sid, cur.d, m_verr});
        rst = 1'b0; cfg_we = 1'b0; start = 1'b0;
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic run_idle();
        int k;
        k = 0;
        while (!((q.size() == 0) && !cur.sid && !cur.dn) && (k < 40)) begin
            idle_tick();
            k++;
        end
        chk("run_bound", 32'(k < 40), 32'd1);
    endtask

    task automatic chk_chain(input logic [IW-1:0] e0, input logic [IW-1:0] e1,
                             input logic [IW-1:0] e2, input logic [IW-1:0] e3);
        chk("chain_col0", chain[0], e0);
        chk("chain_col1", chain[1], e1);
        chk("chain_col2", chain[2], e2);
        chk("chain_col3", chain[3], e3);
    endtask

    function automatic vec_t mkv(logic r, logic we, logic [1:0] a, logic [IW-1:0] wd, logic st,
                                 logic sid, logic [IW-1:0] d, logic bsy, logic dn);
        vec_t v;
        v.r = r; v.we = we; v.a = a; v.wd = wd; v.st = st;
        v.sid = sid; v.d = d; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    vec_t vt [10];

    initial begin
        logic [3:0] tag_mask;
        n_tests = 0; n_fail = 0; done_cnt = 0; sid_cnt = 0;
        cur = '0; m_verr = 1'b0; stuck2 = 1'b0;
        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
        for (int i = 0; i < N; i++) begin
            chain[i] = '0;
            m_tab[i] = '0;
        end
`ifdef GIN_CFG_VERIFY_EN
        verify_on = 1'b1;
`else
        verify_on = 1'b0;
`endif

        //             r  we a     wd    st   sid d     bsy dn
        vt[0] = mkv(1, 0, 2'd0, 4'd0, 0,   0, 4'd0, 0, 0);
        vt[1] = mkv(1, 0, 2'd0, 4'd0, 0,   0, 4'd0, 0, 0);
        vt[2] = mkv(0, 1, 2'd0, 4'd3, 0,   0, 4'd0, 0, 0);
        vt[3] = mkv(0, 1, 2'd1, 4'd7, 0,   0, 4'd0, 0, 0);
        vt[4] = mkv(0, 1, 2'd2, 4'd1, 0,   0, 4'd0, 0, 0);
        vt[5] = mkv(0, 1, 2'd3, 4'd5, 0,   0, 4'd0, 0, 0);
        vt[6] = mkv(0, 0, 2'd0, 4'd0, 1,   1, 4'd5, 1, 0);
        vt[7] = mkv(0, 0, 2'd0, 4'd0, 0,   1, 4'd1, 1, 0);
        vt[8] = mkv(0, 0, 2'd0, 4'd0, 0,   1, 4'd7, 1, 0);
        vt[9] = mkv(0, 0, 2'd0, 4'd0, 0,   1, 4'd3, 1, 0);

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            tick(vt[i].r, vt[i].we, vt[i].a, vt[i].wd, vt[i].st);
            chk("vec", {set_id, ID_scan_in, busy, done}, {vt[i].sid, vt[i].d, vt[i].bsy, vt[i].dn});
            if (i == 1) chk("reset_verify_err", 32'(verify_err), 32'd0);
        end
        run_idle();
        chk("done_count", done_cnt, 1);
        chk("set_id_cycles", sid_cnt, verify_on ? 2 * N : N);
        chk_chain(4'd3, 4'd7, 4'd1, 4'd5);
        tag_mask = '0;
        for (int i = 0; i < N; i++) tag_mask[i] = (chain[i] == 4'd7);
        chk("tag7_cols", 32'(tag_mask), 32'h2);

        // start and cfg_we while busy are both dropped
        done_cnt = 0;
        tick(1'b0, 1'b0, 2'd0, '0, 1'b1);
        idle_tick();
        tick(1'b0, 1'b1, 2'd0, 4'd15, 1'b1);
        tick(1'b0, 1'b1, 2'd2, 4'd9, 1'b0);
        run_idle();
        repeat (3) idle_tick();
        chk("done_count_busy", done_cnt, 1);
        chk_chain(4'd3, 4'd7, 4'd1, 4'd5);

        // rst during the 2nd set_id cycle, then a full re-load
        tick(1'b0, 1'b0, 2'd0, '0, 1'b1);
        idle_tick();
        tick(1'b1, 1'b0, 2'd0, '0, 1'b0);
        chk("busy_after_rst", 32'(busy), 32'd0);
        idle_tick();
        tick(1'b0, 1'b0, 2'd0, '0, 1'b1);
        run_idle();
        chk_chain(4'd3, 4'd7, 4'd1, 4'd5);

        // write and start on the same edge: new value is shifted first
        tick(1'b0, 1'b1, 2'd3, 4'd9, 1'b1);
        chk("fwd_first_shift", 32'(ID_scan_in), 32'd9);
        run_idle();
        chk_chain(4'd3, 4'd7, 4'd1, 4'd9);

        if (verify_on) begin
            stuck2 = 1'b1;
            tick(1'b0, 1'b0, 2'd0, '0, 1'b1);
            run_idle();
            chk("verify_err_stuck", 32'(verify_err), 32'd1);
            stuck2 = 1'b0;
            tick(1'b0, 1'b0, 2'd0, '0, 1'b1);
            run_idle();
            chk("verify_err_clean", 32'(verify_err), 32'd0);
            chk_chain(4'd3, 4'd7, 4'd1, 4'd9);
        end

        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)),
                 IW'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0));
        end
        run_idle();
        tick(1'b0, 1'b0, 2'd0, '0, 1'b1);
        run_idle();
        chk_chain(m_tab[0], m_tab[1], m_tab[2], m_tab[3]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
